// File: rtl/qpu_time_event_sched.sv
// Timed issue stage: releases the paired TIQ/EVQ heads when the run timer reaches the
// TIQ timestamp and presents one registered event per cycle to the control interface.
module qpu_time_event_sched #(
    parameter int TIME_W = 32,
    parameter int EVT_W  = 32,
    parameter int EVT_N  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run_start_i,
    input  logic              run_stop_i,
    input  logic              err_clr_i,
    input  logic              tiq_o_valid,
    input  logic [TIME_W-1:0] tiq_o_data,
    output logic              tiq_o_ready,
    input  logic              evq_o_valid,
    input  logic [EVT_W-1:0]  evq_o_data,
    input  logic [EVT_N-1:0]  evq_o_oprand,
    output logic              evq_o_ready,
    output logic              evt_o_valid,
    output logic [EVT_W-1:0]  evt_o_data,
    output logic [EVT_N-1:0]  evt_o_oprand,
    output logic              sched_busy_o,
    output logic [TIME_W-1:0] sched_time_o,
    output logic              late_err_o,
    output logic              time_ovf_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [TIME_W-1:0] TIME_MAX  = {TIME_W{1'b1}};
    localparam logic [TIME_W-1:0] TIME_ZERO = {TIME_W{1'b0}};

    state_t              state_r;
    state_t              state_nxt_s;
    logic [TIME_W-1:0]   timer_r;
    logic [TIME_W-1:0]   timer_nxt_s;
    logic                busy_r;
    logic                late_r;
    logic                ovf_r;
    logic                late_nxt_s;
    logic                ovf_nxt_s;
    logic                fire_s;
    logic                late_hit_s;
    logic                ovf_hit_s;
    logic                evt_valid_r;
    logic [EVT_W-1:0]    evt_data_r;
    logic [EVT_N-1:0]    evt_oprand_r;

    // Run-control next state and run-timer next value
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = timer_r;
        case (state_r)
            ST_IDLE: begin
                if (run_start_i && !run_stop_i) begin
                    state_nxt_s = ST_RUN;
                    timer_nxt_s = TIME_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                    timer_nxt_s = timer_r;
                end
            end
            ST_RUN: begin
                // The timer freezes on the stop edge, so the stop-time value stays visible.
                if (run_stop_i) begin
                    state_nxt_s = ST_IDLE;
                    timer_nxt_s = timer_r;
                end else if (timer_r != TIME_MAX) begin
                    state_nxt_s = ST_RUN;
                    timer_nxt_s = timer_r + TIME_W'(1'b1);
                end else begin
                    state_nxt_s = ST_RUN;
                    timer_nxt_s = timer_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                timer_nxt_s = timer_r;
            end
        endcase
    end

    // Release decision and sticky-flag update (a set in the same cycle beats a clear)
    always_comb begin
        fire_s     = (state_r == ST_RUN) && tiq_o_valid && evq_o_valid &&
                     (tiq_o_data <= timer_r);
        late_hit_s = fire_s && (tiq_o_data < timer_r);
        ovf_hit_s  = (state_r == ST_RUN) && (timer_r == TIME_MAX);
        if (late_hit_s) begin
            late_nxt_s = 1'b1;
        end else if (err_clr_i) begin
            late_nxt_s = 1'b0;
        end else begin
            late_nxt_s = late_r;
        end
        if (ovf_hit_s) begin
            ovf_nxt_s = 1'b1;
        end else if (err_clr_i) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // Run-control state, timer and status flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            timer_r <= TIME_ZERO;
            busy_r  <= 1'b0;
            late_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            timer_r <= timer_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN);
            late_r  <= late_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

    // Issue register: strobe for one cycle, payload held between issues
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid_r  <= 1'b0;
            evt_data_r   <= {EVT_W{1'b0}};
            evt_oprand_r <= {EVT_N{1'b0}};
        end else begin
            evt_valid_r <= fire_s;
            if (fire_s) begin
                evt_data_r   <= evq_o_data;
                evt_oprand_r <= evq_o_oprand;
            end else begin
                evt_data_r   <= evt_data_r;
                evt_oprand_r <= evt_oprand_r;
            end
        end
    end

    assign tiq_o_ready  = fire_s;
    assign evq_o_ready  = fire_s;
    assign evt_o_valid  = evt_valid_r;
    assign evt_o_data   = evt_data_r;
    assign evt_o_oprand = evt_oprand_r;
    assign sched_busy_o = busy_r;
    assign sched_time_o = timer_r;
    assign late_err_o   = late_r;
    assign time_ovf_o   = ovf_r;

endmodule

// File: tb/tb_qpu_time_event_sched.sv
// Bench for qpu_time_event_sched: bench-owned TIQ/EVQ, a cycle-level reference model
// of the run/timer/flag rules, and a scoreboard monitor for issued events.
module tb_qpu_time_event_sched;

    localparam int TW = 4;
    localparam int EW = 32;
    localparam int EN = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run_start_i, run_stop_i, err_clr_i;
    logic          tiq_o_valid, tiq_o_ready;
    logic [TW-1:0] tiq_o_data;
    logic          evq_o_valid, evq_o_ready;
    logic [EW-1:0] evq_o_data;
    logic [EN-1:0] evq_o_oprand;
    logic          evt_o_valid;
    logic [EW-1:0] evt_o_data;
    logic [EN-1:0] evt_o_oprand;
    logic          sched_busy_o;
    logic [TW-1:0] sched_time_o;
    logic          late_err_o, time_ovf_o;

    always #5 clk = ~clk;

    qpu_time_event_sched #(.TIME_W(TW), .EVT_W(EW), .EVT_N(EN)) dut (
        .clk(clk), .rst_n(rst_n),
        .run_start_i(run_start_i), .run_stop_i(run_stop_i), .err_clr_i(err_clr_i),
        .tiq_o_valid(tiq_o_valid), .tiq_o_data(tiq_o_data), .tiq_o_ready(tiq_o_ready),
        .evq_o_valid(evq_o_valid), .evq_o_data(evq_o_data), .evq_o_oprand(evq_o_oprand),
        .evq_o_ready(evq_o_ready),
        .evt_o_valid(evt_o_valid), .evt_o_data(evt_o_data), .evt_o_oprand(evt_o_oprand),
        .sched_busy_o(sched_busy_o), .sched_time_o(sched_time_o),
        .late_err_o(late_err_o), .time_ovf_o(time_ovf_o)
    );

    typedef struct {
        logic [EW-1:0] d;
        logic [EN-1:0] o;
        int            due;
    } exp_t;

    exp_t                exp_q[$];
    logic [TW-1:0]       tq[$];
    logic [EW+EN-1:0]    eq[$];
    bit                  evq_en;
    int                  checks = 0;
    int                  failures = 0;
    int                  cyc = 0;
    bit                  m_run, m_late, m_ovf;
    logic [TW-1:0]       m_timer;
    logic [EW-1:0]       last_d;
    logic [EN-1:0]       last_o;
    bit                  pop_t, pop_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic refresh();
        tiq_o_valid = (tq.size() > 0);
        tiq_o_data  = '0;
        if (tq.size() > 0) tiq_o_data = tq[0];
        evq_o_valid  = evq_en && (eq.size() > 0);
        evq_o_data   = '0;
        evq_o_oprand = '0;
        if (eq.size() > 0) {evq_o_data, evq_o_oprand} = eq[0];
    endtask

    task automatic push(input logic [TW-1:0] ts, input logic [EW-1:0] d, input logic [EN-1:0] o);
        tq.push_back(ts);
        eq.push_back({d, o});
        refresh();
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_late = 1'b0; m_ovf = 1'b0; m_timer = '0;
        last_d = '0; last_o = '0;
        exp_q.delete();
    endtask

    // Reference: one cycle of the scheduling rules, evaluated mid-cycle on settled inputs
    task automatic model_eval();
        bit fire;
        bit late_set, ovf_set;
        exp_t e;
        fire = m_run && tiq_o_valid && evq_o_valid && (tq[0] <= m_timer);
        chk("tiq_ready", tiq_o_ready, fire);
        chk("evq_ready", evq_o_ready, fire);
        chk("busy", sched_busy_o, m_run);
        chk("time", sched_time_o, m_timer);
        chk("late_err", late_err_o, m_late);
        chk("time_ovf", time_ovf_o, m_ovf);
        pop_t = tiq_o_ready;
        pop_e = evq_o_ready;
        if (fire) begin
            {e.d, e.o} = eq[0];
            e.due = cyc + 1;
            exp_q.push_back(e);
        end
        late_set = fire && (tq[0] < m_timer);
        ovf_set  = m_run && (m_timer == {TW{1'b1}});
        m_late = late_set ? 1'b1 : (err_clr_i ? 1'b0 : m_late);
        m_ovf  = ovf_set  ? 1'b1 : (err_clr_i ? 1'b0 : m_ovf);
        if (!m_run && run_start_i && !run_stop_i) m_timer = '0;
        else if (m_run && !run_stop_i && m_timer != {TW{1'b1}}) m_timer = m_timer + 4'd1;
        if (run_stop_i) m_run = 1'b0;
        else if (run_start_i) m_run = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        cyc++;
        if (pop_t && tq.size() > 0) void'(tq.pop_front());
        if (pop_e && eq.size() > 0) void'(eq.pop_front());
        #1;
        run_start_i = 1'b0;
        run_stop_i  = 1'b0;
        err_clr_i   = 1'b0;
        refresh();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_timer(input logic [TW-1:0] t);
        int n = 0;
        while (m_timer != t && n < 40) begin
            step();
            n++;
        end
        chk("wait_timer", sched_time_o, t);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_evt_valid"}, evt_o_valid, 1'b0);
        chk({tag, "_evt_data"}, evt_o_data, '0);
        chk({tag, "_evt_oprand"}, evt_o_oprand, '0);
        chk({tag, "_busy"}, sched_busy_o, 1'b0);
        chk({tag, "_time"}, sched_time_o, '0);
        chk({tag, "_late"}, late_err_o, 1'b0);
        chk({tag, "_ovf"}, time_ovf_o, 1'b0);
        chk({tag, "_tiq_ready"}, tiq_o_ready, 1'b0);
        chk({tag, "_evq_ready"}, evq_o_ready, 1'b0);
    endtask

    // Scoreboard monitor: every issue must match the oldest expected event on its due cycle
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (evt_o_valid) begin
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    e = exp_q.pop_front();
                    chk("evt_data", evt_o_data, e.d);
                    chk("evt_oprand", evt_o_oprand, e.o);
                    last_d = e.d;
                    last_o = e.o;
                end else begin
                    chk("evt_valid_unexpected", evt_o_valid, 1'b0);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                chk("evt_valid_missing", evt_o_valid, 1'b1);
                last_d = e.d;
                last_o = e.o;
            end else begin
                chk("evt_data_hold", evt_o_data, last_d);
                chk("evt_oprand_hold", evt_o_oprand, last_o);
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        run_start_i = 1'b0; run_stop_i = 1'b0; err_clr_i = 1'b0;
        evq_en = 1'b1;
        model_reset();
        refresh();
        #2;
        check_zero("por");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        steps(2);

        // Two timed entries: A at ts=5, B at ts=9, both on time
        push(4'd5, 32'hA000_0005, 8'h01);
        push(4'd9, 32'hB000_0009, 8'h82);
        run_start_i = 1'b1;
        steps(14);
        chk("t2_late", late_err_o, 1'b0);
        chk("t2_drained", tq.size(), 0);
        run_stop_i = 1'b1;
        steps(2);

        // Equal timestamps: the second one issues a cycle later and is late
        push(4'd3, 32'hC000_0003, 8'h03);
        push(4'd3, 32'hD000_0003, 8'h04);
        run_start_i = 1'b1;
        steps(8);
        chk("t3_late_set", late_err_o, 1'b1);
        err_clr_i = 1'b1;
        steps(2);
        chk("t3_late_clr", late_err_o, 1'b0);
        run_stop_i = 1'b1;
        steps(2);

        // TIQ due at 2 but EVQ only presents at timer=7
        evq_en = 1'b0;
        push(4'd2, 32'hE000_0002, 8'h10);
        run_start_i = 1'b1;
        step();
        run_until_timer(4'd7);
        evq_en = 1'b1;
        refresh();
        steps(3);
        chk("t4_late", late_err_o, 1'b1);
        run_stop_i = 1'b1;
        err_clr_i = 1'b1;
        steps(2);

        // Start and stop together from IDLE; then stop with an entry pending
        run_start_i = 1'b1;
        run_stop_i = 1'b1;
        steps(2);
        chk("t5_idle", sched_busy_o, 1'b0);
        push(4'd8, 32'hF000_0008, 8'h20);
        run_start_i = 1'b1;
        step();
        run_until_timer(4'd4);
        run_stop_i = 1'b1;
        steps(4);
        chk("t5_time_hold", sched_time_o, 4'd4);
        chk("t5_pending", tq.size(), 1);

        // Saturation: the pending ts=8 entry and a ts=15 entry both issue
        run_start_i = 1'b1;
        step();
        push(4'd15, 32'h1500_000F, 8'h40);
        steps(20);
        chk("t6_time_sat", sched_time_o, 4'd15);
        chk("t6_ovf", time_ovf_o, 1'b1);
        chk("t6_late", late_err_o, 1'b0);
        chk("t6_drained", tq.size(), 0);

        // Asynchronous reset while an event is on the output
        push(4'd3, 32'h0BAD_0003, 8'h0F);
        step();
        chk("t1_pre_valid", evt_o_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_zero("t1_rst");
        model_reset();
        @(posedge clk);
        cyc++;
        #1 rst_n = 1'b1;
        steps(2);

        // Randomized traffic and run control
        for (int r = 0; r < 6; r++) begin
            run_start_i = 1'b1;
            for (int c = 0; c < 60; c++) begin
                if ($urandom_range(0, 9) < 3 && tq.size() < 6)
                    push(TW'($urandom_range(0, 15)), $urandom, EN'($urandom_range(0, 255)));
                if ($urandom_range(0, 7) == 0) begin
                    evq_en = ~evq_en;
                    refresh();
                end
                if ($urandom_range(0, 39) == 0) run_stop_i = 1'b1;
                if ($urandom_range(0, 19) == 0) run_start_i = 1'b1;
                if ($urandom_range(0, 24) == 0) err_clr_i = 1'b1;
                step();
            end
        end

        // Drain whatever is left, then check the scoreboard is empty
        evq_en = 1'b1;
        refresh();
        run_start_i = 1'b1;
        step();
        n = 0;
        while (tq.size() > 0 && n < 60) begin
            step();
            n++;
        end
        run_stop_i = 1'b1;
        steps(3);
        chk("queues_drained", tq.size(), 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
